// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst read/write initiator for a single-port RAM with power-on zero-fill
module ram_burst_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [DEPTH-1:0] cmd_addr,
  input  logic [DEPTH-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             init_done,
  output logic             ram_en,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_RESP
  } state_e;

  localparam logic [DEPTH-1:0] LAST_ADDR = '1;

  state_e           state_q;
  logic [DEPTH-1:0] init_cnt_q;
  logic [DEPTH-1:0] addr_q;
  logic [DEPTH-1:0] beats_q;
  logic             init_done_q;
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      addr_q      <= '0;
      beats_q     <= '0;
      init_done_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ADDR) begin
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            beats_q <= cmd_len;
            state_q <= cmd_write ? S_WRITE : S_RD_ADDR;
          end
        end
        S_WRITE: begin
          if (wr_valid) begin
            addr_q <= addr_q + 1'b1;
            if (beats_q == '0) state_q <= S_IDLE;
            else               beats_q <= beats_q - 1'b1;
          end
        end
        S_RD_ADDR: state_q <= S_RD_WAIT;
        // The RAM registered the read on the RD_ADDR edge, so its output is valid now.
        S_RD_WAIT: begin
          rd_data_q <= ram_rdata;
          state_q   <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (rd_ready) begin
            addr_q <= addr_q + 1'b1;
            if (beats_q == '0) begin
              state_q <= S_IDLE;
            end else begin
              beats_q <= beats_q - 1'b1;
              state_q <= S_RD_ADDR;
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WRITE);
  assign rd_valid  = (state_q == S_RD_RESP);
  assign rd_last   = (state_q == S_RD_RESP) && (beats_q == '0);
  assign rd_data   = rd_data_q;
  assign busy      = (state_q != S_IDLE);
  assign init_done = init_done_q;

  // Write enable is only ever raised by INIT or a live write beat.
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = '0;
    case (state_q)
      S_INIT: begin
        ram_en   = 1'b1;
        ram_addr = init_cnt_q;
      end
      S_WRITE: begin
        ram_en    = wr_valid;
        ram_wdata = wr_valid ? wr_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Initiator-side controller for the team's single-port RAM (write when enable high, registered read when enable low). It zero-fills the memory after reset, then accepts burst read/write commands on a valid/ready command channel. Write beats are streamed into the RAM and read beats are returned on a valid/ready response stream. It sits between any client datapath and one single-port RAM instance. It is the only agent driving that RAM's enable, address and write-data pins.

## Interface
- WIDTH, 8, data width; must match the attached RAM.
- DEPTH, 4, address width; the RAM holds 2**DEPTH words.

- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  DEPTH  start address.
- cmd_len  in  DEPTH  beats minus 1 (0 → 1 beat, 2**DEPTH-1 → full memory).
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted.
- wr_data  in  WIDTH  write beat data.
- rd_valid  out  1  read beat present.
- rd_ready  in  1  read beat consumed.
- rd_data  out  WIDTH  read beat data, registered.
- rd_last  out  1  final beat of the read burst (qualified by rd_valid).
- busy  out  1  not in IDLE.
- init_done  out  1  zero-fill complete; sticky until reset.
- ram_en  out  1  RAM write enable (1 = write, 0 = read).
- ram_addr  out  DEPTH  RAM address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_rdata  in  WIDTH  RAM registered read data.

## Operation
- FSM states: INIT, IDLE, WRITE, RD_ADDR, RD_WAIT, RD_RESP.
- **INIT** (entered on reset):
  - ram_en=1, ram_wdata=0, ram_addr=init counter 0..2**DEPTH-1, one word per cycle.
  - After the word at 2**DEPTH-1: init_done←1, go to IDLE.
- **IDLE**: cmd_ready=1.
  - On handshake, latch addr←cmd_addr and beats←cmd_len.
  - Go to WRITE if cmd_write, else RD_ADDR.
- **WRITE**: wr_ready=1.
  - On wr_valid: ram_en=1, ram_addr=addr, ram_wdata=wr_data in the same cycle. Then addr←addr+1.
  - If beats==0, go to IDLE; else beats←beats-1.
  - When wr_valid=0, ram_en=0 and no state change (stall of any length).
- **RD_ADDR**: ram_en=0, ram_addr=addr → RD_WAIT.
- **RD_WAIT**: ram_en=0, ram_addr=addr held. rd_data←ram_rdata → RD_RESP.
- **RD_RESP**: rd_valid=1, rd_last=(beats==0). rd_data is held stable until rd_ready.
  - On rd_ready: addr←addr+1.
  - If beats==0, go to IDLE; else beats←beats-1 and go to RD_ADDR.
- ram_en is 1 only in INIT, or in WRITE with wr_valid. It is 0 in all other states, so the RAM never sees a spurious write.
- ram_* outputs are combinational from the state registers plus wr_valid/wr_data only.
- Address arithmetic is modulo 2**DEPTH. A burst crossing 2**DEPTH-1 wraps to 0.
- cmd_valid is ignored outside IDLE, with cmd_ready=0 there. wr_valid outside WRITE is ignored, with wr_ready=0.

## Timing
- Reset values:
  - state=INIT, init counter=0.
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0.
  - busy=1, init_done=0.
  - ram_en=1, ram_addr=0, ram_wdata=0 (INIT drive).
- rstn assertion at any time (mid-burst, mid-INIT) aborts immediately.
  - Pending beats are discarded. The zero-fill restarts from address 0 after release.
- Zero-fill lasts exactly 2**DEPTH cycles after the first rising edge with rstn=1. cmd_ready rises the following cycle.
- Command to first write: the cycle after the command handshake, wr_ready=1.
- Write throughput: 1 beat/cycle with continuous wr_valid. Burst of N beats with no stalls occupies N cycles in WRITE.
- Read latency: the command handshake edge is followed by 1 cycle RD_ADDR, 1 cycle RD_WAIT, then rd_valid. First beat appears on the 3rd cycle after the handshake.
- Read throughput: 3 cycles/beat with rd_ready held 1. Backpressure extends RD_RESP indefinitely.
- Back-to-back commands: after the final beat, IDLE asserts cmd_ready the next cycle (1 idle cycle between bursts).

## Test plan
- Reset release with DEPTH=4: 16 cycles of ram_en=1, ram_wdata=0, ram_addr 0→15. init_done=1 and cmd_ready=1 on cycle 17.
- Write burst addr=3, len=3, data 0xA1,0xA2,0xA3,0xA4, then read burst addr=3, len=3: rd_data 0xA1..0xA4, rd_last only on 0xA4, first rd_valid 3 cycles after the read handshake.
- Wrap: write addr=14, len=3, data 0x11,0x22,0x33,0x44 → RAM addresses 14,15,0,1. Read-back addr=14 returns the same order.
- Stalls: insert wr_valid=0 gaps and hold rd_ready=0 for 5 cycles. ram_en=0 during gaps; rd_data/rd_last stay stable; no beat lost or duplicated.
- Read of untouched address 9 after reset returns 0x00. A single-beat read (len=0) asserts rd_last on its only beat.
- rstn pulse low mid-write burst (after 2 of 4 beats): outputs return to reset values asynchronously. The zero-fill reruns and a subsequent read of those addresses returns 0x00.
